// File: rtl/tdoa_stimulus_generator.sv
// Synthetic three-microphone PCM source for in-system checking of the TDOA correlator.
// It emits a square-wave burst on pcm_1 and copies of that burst on pcm_2/pcm_3, delayed by a programmable number of samples.
module tdoa_stimulus_generator #(
    parameter int PERIOD     = 16,
    parameter int AMP        = 8000,
    parameter int BIAS       = 2048,
    parameter int BURST_LEN  = 64,
    parameter int PRE_LEN    = 32,
    parameter int POST_LEN   = 32,
    parameter int NOISE_BITS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic        start,
    input  logic [7:0]  delay_2,
    input  logic [7:0]  delay_3,
    output logic [15:0] pcm_1,
    output logic [15:0] pcm_2,
    output logic [15:0] pcm_3,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = $clog2(PRE_LEN + BURST_LEN + POST_LEN + 256);
    localparam int PH_W  = $clog2(PERIOD);
    localparam int NSH   = 18 - NOISE_BITS;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_BURST, S_POST} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_delay_2;
    logic [7:0]         r_delay_3;
    logic               r_busy;
    logic               r_done;
    logic [15:0]        r_pcm   [3];
    logic [15:0]        r_lfsr  [3];
    logic [PH_W-1:0]    r_phase [3];

    logic [7:0]         w_d       [3];
    logic [2:0]         w_in_win;
    logic [7:0]         w_dmax;
    logic [CNT_W-1:0]   w_burst_end;

    // Taps 16,14,13,11 in right-shifting Fibonacci form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // The low NOISE_BITS of the LFSR become signed noise: shift them to the top bits, then shift them back arithmetically.
    // This needs no zero-width slice when NOISE_BITS is 0.
    function automatic logic [15:0] sample_value(input logic in_win, input logic high,
                                                 input logic [15:0] lfsr);
        logic signed [17:0] base;
        logic signed [17:0] noise;
        logic signed [17:0] sum;
        logic        [17:0] shl;
        // NOTE: function locals use blocking assignments because they are pure combinational temporaries, not state.
        base  = in_win ? (high ? 18'(BIAS + AMP) : 18'(BIAS - AMP)) : 18'(BIAS);
        shl   = {2'b00, lfsr} << NSH;
        noise = $signed(shl) >>> NSH;
        sum   = base + noise;
        if (sum > 18'sd32767)
            return 16'h7FFF;
        else if (sum < -18'sd32768)
            return 16'h8000;
        else
            return sum[15:0];
    endfunction

    always_comb begin
        w_d[0]      = 8'd0;
        w_d[1]      = r_delay_2;
        w_d[2]      = r_delay_3;
        w_dmax      = (r_delay_2 > r_delay_3) ? r_delay_2 : r_delay_3;
        w_burst_end = CNT_W'(BURST_LEN) + CNT_W'(w_dmax) - CNT_W'(1);
        w_in_win    = '0;
        for (int k = 0; k < 3; k++) begin
            w_in_win[k] = (r_state == S_BURST)
                       && (r_cnt >= CNT_W'(w_d[k]))
                       && (r_cnt <  CNT_W'(w_d[k]) + CNT_W'(BURST_LEN));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the small per-channel arrays sit in flops, so every element is reset explicitly; none of them is a RAM.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_delay_2 <= '0;
            r_delay_3 <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lfsr[0] <= 16'hACE1;
            r_lfsr[1] <= 16'h1D2B;
            r_lfsr[2] <= 16'h7F3C;
            for (int k = 0; k < 3; k++) begin
                r_pcm[k]   <= 16'(BIAS);
                r_phase[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;

            if (sample_en) begin
                for (int k = 0; k < 3; k++) begin
                    r_pcm[k]  <= sample_value(w_in_win[k],
                                              r_phase[k] < PH_W'(PERIOD / 2), r_lfsr[k]);
                    r_lfsr[k] <= lfsr_next(r_lfsr[k]);
                    if (w_in_win[k])
                        r_phase[k] <= (r_phase[k] == PH_W'(PERIOD - 1)) ? '0 : r_phase[k] + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_delay_2 <= delay_2;
                        r_delay_3 <= delay_3;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_PRE;
                        for (int k = 0; k < 3; k++)
                            r_phase[k] <= '0;
                    end
                end
                S_PRE: begin
                    if (sample_en) begin
                        if (r_cnt == CNT_W'(PRE_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_BURST;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (sample_en) begin
                        if (r_cnt == w_burst_end) begin
                            r_cnt   <= '0;
                            r_state <= S_POST;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_POST: begin
                    if (sample_en) begin
                        if (r_cnt == CNT_W'(POST_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pcm_1 = r_pcm[0];
    assign pcm_2 = r_pcm[1];
    assign pcm_3 = r_pcm[2];
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_tdoa_stimulus_generator.sv
// Directed bench for tdoa_stimulus_generator: one clean instance with default parameters and one saturating, noisy instance.
// All expected samples are computed from sample index, delay, amplitude and an LFSR noise model.
module tb_tdoa_stimulus_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic        start;
    logic        start_n;
    logic [7:0]  delay_2;
    logic [7:0]  delay_3;
    logic [15:0] pcm_1, pcm_2, pcm_3;
    logic [15:0] npcm_1, npcm_2, npcm_3;
    logic        busy, done, nbusy, ndone;

    int n_tests = 0;
    int n_fail  = 0;
    int lf [3];
    int nz [3];

    always #5 clk = ~clk;

    tdoa_stimulus_generator u_dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .start(start),
        .delay_2(delay_2), .delay_3(delay_3),
        .pcm_1(pcm_1), .pcm_2(pcm_2), .pcm_3(pcm_3), .busy(busy), .done(done)
    );

    tdoa_stimulus_generator #(.AMP(30000), .BIAS(5000), .NOISE_BITS(12)) u_noisy (
        .clk(clk), .reset(reset), .sample_en(sample_en), .start(start_n),
        .delay_2(delay_2), .delay_3(delay_3),
        .pcm_1(npcm_1), .pcm_2(npcm_2), .pcm_3(npcm_3), .busy(nbusy), .done(ndone)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Ideal channel value for sample s of a sequence, with the default 32-sample lead-in.
    function automatic int exp_ch(input int s, input int d, input int amp, input int bias);
        int w;
        w = s - 32 - d;
        if (w >= 0 && w < 64)
            return ((w % 16) < 8) ? bias + amp : bias - amp;
        return bias;
    endfunction

    function automatic int noise12(input int l);
        int n;
        n = l & 'hFFF;
        if (n >= 2048) n -= 4096;
        return n;
    endfunction

    function automatic int lfsr_step(input int l);
        int b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    task automatic seed_model();
        lf[0] = 'hACE1;
        lf[1] = 'h1D2B;
        lf[2] = 'h7F3C;
    endtask

    // Apply one sample strobe, then return at the following negedge. The noise used for that sample is stored in nz.
    task automatic tick_sample();
        @(negedge clk) sample_en = 1'b1;
        @(negedge clk) sample_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nz[k] = noise12(lf[k]);
            lf[k] = lfsr_step(lf[k]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pcm_1"}, int'($signed(pcm_1)), 2048);
        check({tag, " pcm_2"}, int'($signed(pcm_2)), 2048);
        check({tag, " pcm_3"}, int'($signed(pcm_3)), 2048);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " npcm_1"}, int'($signed(npcm_1)), 5000);
        check({tag, " nbusy"}, int'(nbusy), 0);
    endtask

    // Start a sequence on one instance and check every sample on both instances.
    // The call returns at the negedge where done is visible, or right after the reset when abort_at is used.
    task automatic run_seq(input string t, input bit noisy, input int d2, input int d3,
                           input int repulse_at, input int abort_at);
        int total;
        int d [3];
        int e;
        d[0] = 0; d[1] = d2; d[2] = d3;
        total = 32 + 64 + ((d2 > d3) ? d2 : d3) + 32;
        delay_2 = 8'(d2);
        delay_3 = 8'(d3);
        if (noisy) start_n = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_n = 1'b0;
        delay_2 = 8'hAA; delay_3 = 8'h55;
        check({t, " busy after start"}, int'(noisy ? nbusy : busy), 1);
        for (int s = 0; s < total; s++) begin
            if (s == abort_at) begin
                reset = 1'b1; sample_en = 1'b1;
                @(negedge clk);
                reset = 1'b0; sample_en = 1'b0;
                seed_model();
                check_reset_state($sformatf("%s abort", t));
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check($sformatf("%s no done c%0d", t, c), int'(done), 0);
                end
                return;
            end
            if (s == repulse_at) begin
                start = 1'b1; delay_2 = 8'd20; delay_3 = 8'd1;
                @(negedge clk);
                start = 1'b0;
            end
            tick_sample();
            for (int k = 0; k < 3; k++) begin
                e = noisy ? 2048 : exp_ch(s, d[k], 8000, 2048);
                check($sformatf("%s pcm_%0d s%0d", t, k + 1, s),
                      int'($signed(k == 0 ? pcm_1 : (k == 1 ? pcm_2 : pcm_3))), e);
                e = sat16((noisy ? exp_ch(s, d[k], 30000, 5000) : 5000) + nz[k]);
                check($sformatf("%s npcm_%0d s%0d", t, k + 1, s),
                      int'($signed(k == 0 ? npcm_1 : (k == 1 ? npcm_2 : npcm_3))), e);
            end
            if (d2 == 0 && d3 == 0 && !noisy)
                check($sformatf("%s equal s%0d", t, s),
                      int'(pcm_1 == pcm_2 && pcm_2 == pcm_3), 1);
            check($sformatf("%s done s%0d", t, s), int'(noisy ? ndone : done),
                  int'(s == total - 1));
            check($sformatf("%s busy s%0d", t, s), int'(noisy ? nbusy : busy),
                  int'(s != total - 1));
            check($sformatf("%s other done s%0d", t, s), int'(noisy ? done : ndone), 0);
        end
    endtask

    task automatic expect_done_low(input string t);
        @(negedge clk);
        check({t, " done falls"}, int'(done | ndone), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sample_en = 1'b0; start = 1'b0; start_n = 1'b0;
        delay_2 = 8'd0; delay_3 = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        seed_model();
        check_reset_state("reset");

        // Idle samples carry noise only.
        for (int s = 0; s < 6; s++) begin
            tick_sample();
            check($sformatf("idle pcm_1 s%0d", s), int'($signed(pcm_1)), 2048);
            check($sformatf("idle npcm_2 s%0d", s), int'($signed(npcm_2)), 5000 + nz[1]);
        end

        run_seq("t1", 1'b0, 5, 12, -1, -1);
        expect_done_low("t1");
        run_seq("t2", 1'b0, 0, 0, -1, -1);
        expect_done_low("t2");
        run_seq("t3", 1'b0, 255, 0, -1, -1);
        expect_done_low("t3");
        // Restart in the clock where done is high.
        run_seq("t4a", 1'b0, 5, 12, 40, -1);
        run_seq("t4b", 1'b0, 3, 7, -1, -1);
        expect_done_low("t4b");
        run_seq("t5", 1'b1, 0, 0, -1, -1);
        expect_done_low("t5");
        run_seq("t6a", 1'b0, 5, 12, -1, 50);
        run_seq("t6b", 1'b0, 5, 12, -1, -1);
        expect_done_low("t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
